// File: rtl/nano_mem_arbiter.sv
// nano_mem_arbiter: shares one single-port memory between NanoRisc fetch (F) and
// data (D) ports. Data wins ties unless fetch has waited through MAX_DATA_STREAK
// data grants. One transaction at a time; a silent memory is cut off after
// TIMEOUT_CYCLES busy cycles and the requester still gets a ready pulse with err set.
module nano_mem_arbiter #(
   parameter int ADDR_WIDTH      = 8,
   parameter int DATA_WIDTH      = 8,
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 15
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  f_req,
   input  logic [ADDR_WIDTH-1:0] f_addr,
   output logic                  f_ready,
   output logic [DATA_WIDTH-1:0] f_rdata,
   output logic                  f_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ready,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_err,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  busy
);

   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_BUSY_F, S_BUSY_D, S_RESP_F, S_RESP_D} state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         streak_q, streak_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_we_q, mem_we_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  f_err_q, f_err_d;
   logic                  d_err_q, d_err_d;
   logic                  ack_or_timeout;

   // State and datapath registers, all cleared by the synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         streak_q    <= '0;
         timer_q     <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         f_rdata_q   <= '0;
         d_rdata_q   <= '0;
         f_err_q     <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         timer_q     <= timer_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         f_rdata_q   <= f_rdata_d;
         d_rdata_q   <= d_rdata_d;
         f_err_q     <= f_err_d;
         d_err_q     <= d_err_d;
      end
   end

   // Arbitration, transaction sequencing and response capture
   always_comb begin
      state_d        = state_q;
      streak_d       = streak_q;
      timer_d        = timer_q;
      mem_addr_d     = mem_addr_q;
      mem_we_d       = mem_we_q;
      mem_wdata_d    = mem_wdata_q;
      f_rdata_d      = f_rdata_q;
      d_rdata_d      = d_rdata_q;
      f_err_d        = f_err_q;
      d_err_d        = d_err_q;
      ack_or_timeout = mem_ack || (timer_q == TW'(TIMEOUT_CYCLES - 1));
      case (state_q)
         S_IDLE: begin
            // Data wins unless fetch has been passed over MAX_DATA_STREAK times
            if (d_req && !(f_req && streak_q == SW'(MAX_DATA_STREAK))) begin
               state_d     = S_BUSY_D;
               mem_addr_d  = d_addr;
               mem_we_d    = d_we;
               mem_wdata_d = d_wdata;
               timer_d     = '0;
               if (!f_req)
                  streak_d = '0;
               else if (streak_q != SW'(MAX_DATA_STREAK))
                  streak_d = streak_q + 1'b1;
            end else if (f_req) begin
               state_d     = S_BUSY_F;
               mem_addr_d  = f_addr;
               mem_we_d    = 1'b0;
               mem_wdata_d = '0;
               timer_d     = '0;
               streak_d    = '0;
            end
         end
         S_BUSY_F: begin
            if (ack_or_timeout) begin
               state_d = S_RESP_F;
               f_err_d = !mem_ack;
               if (mem_ack) f_rdata_d = mem_rdata;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_BUSY_D: begin
            if (ack_or_timeout) begin
               state_d = S_RESP_D;
               d_err_d = !mem_ack;
               // Stores leave the load-data register untouched
               if (mem_ack && !mem_we_q) d_rdata_d = mem_rdata;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RESP_F, S_RESP_D: state_d = S_IDLE;
         default:            state_d = S_IDLE;
      endcase
   end

   assign mem_en    = (state_q == S_BUSY_F) || (state_q == S_BUSY_D);
   assign mem_we    = mem_en && mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign f_ready   = (state_q == S_RESP_F);
   assign d_ready   = (state_q == S_RESP_D);
   assign f_err     = f_ready && f_err_q;
   assign d_err     = d_ready && d_err_q;
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// Bench for nano_mem_arbiter: transaction-timeline model (grant cycle + busy length
// predicts every output cycle by cycle), a memory responder with a programmable ack
// delay, and directed scenarios with hand-computed literal expectations.
module tb_nano_mem_arbiter;
   localparam int AW = 8, DW = 8, MAXS = 4, TO = 15;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          f_req, d_req, d_we, mem_ack;
   logic [AW-1:0] f_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic          f_ready, f_err, d_ready, d_err, mem_en, mem_we, busy;
   logic [DW-1:0] f_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   always #5 clock = ~clock;

   nano_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS),
                      .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata), .f_err(f_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy));

   int   npass = 0, ntot = 0, cyc = 0;
   bit   armed = 0;
   logic [DW-1:0] tmem [256];
   logic [DW-1:0] m_mem[256];
   int   ack_dly = 0;   // busy cycles before the ack cycle; <0 = never ack
   bit   spur = 0;      // drive mem_ack whenever mem_en is low
   int   en_cnt = 0;

   task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
      ntot++;
      if (a === e) npass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
   endtask

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (reset) armed <= 1'b1;
   end

   // Memory responder
   always @(posedge clock) begin
      #1;
      if (mem_en === 1'b1) begin
         mem_ack   = (en_cnt == ack_dly);
         mem_rdata = mem_ack ? tmem[mem_addr] : 8'h00;
         if (mem_ack && mem_we) tmem[mem_addr] = mem_wdata;
         en_cnt++;
      end else begin
         en_cnt    = 0;
         mem_ack   = spur;
         mem_rdata = spur ? 8'hFF : 8'h00;
      end
   end

   // Model: one active transaction described by grant cycle and busy length
   bit   act = 0, g_d = 0, g_we = 0, g_err = 0;
   int   g_cyc = 0, g_len = 0, streak = 0;
   logic [DW-1:0] g_addr = 0, g_wdata = 0, g_rdata = 0, m_f_rdata = 0, m_d_rdata = 0;

   always @(negedge clock) begin
      bit was_idle, e_en, e_fr, e_dr, e_busy;
      if (armed) begin
         was_idle = !act;
         e_en   = act && cyc > g_cyc && cyc <= g_cyc + g_len;
         e_fr   = act && !g_d && cyc == g_cyc + g_len + 1;
         e_dr   = act && g_d && cyc == g_cyc + g_len + 1;
         e_busy = e_en || e_fr || e_dr;
         if ((e_fr || e_dr) && !g_err) begin
            if (!g_d) m_f_rdata = g_rdata;
            else if (!g_we) m_d_rdata = g_rdata;
            else m_mem[g_addr] = g_wdata;
         end
         chk("busy", busy, e_busy);
         chk("mem_en", mem_en, e_en);
         chk("f_ready", f_ready, e_fr);
         chk("d_ready", d_ready, e_dr);
         chk("f_rdata", f_rdata, m_f_rdata);
         chk("d_rdata", d_rdata, m_d_rdata);
         if (e_en) begin
            chk("mem_addr", mem_addr, g_addr);
            chk("mem_we", mem_we, g_we);
            if (g_we) chk("mem_wdata", mem_wdata, g_wdata);
         end
         if (e_fr) chk("f_err", f_err, g_err);
         if (e_dr) chk("d_err", d_err, g_err);
         if (e_fr || e_dr) act = 0;
         if (reset) begin
            act = 0; streak = 0; m_f_rdata = 0; m_d_rdata = 0;
         end else if (was_idle && (f_req || d_req)) begin
            g_d = d_req && !(f_req && streak == MAXS);
            if (g_d) streak = f_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            else     streak = 0;
            g_addr  = g_d ? d_addr : f_addr;
            g_we    = g_d && d_we;
            g_wdata = d_wdata;
            g_rdata = m_mem[g_addr];
            if (ack_dly >= 0 && ack_dly < TO) begin g_len = ack_dly + 1; g_err = 0; end
            else begin g_len = TO; g_err = 1; end
            g_cyc = cyc;
            act   = 1;
         end
      end
   end

   // One request on one port; reports req-to-ready latency, mem_en cycles, err, rdata
   task automatic run_one(input bit isd, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output int rc, output int ne,
                          output logic err, output logic [DW-1:0] rd);
      int start;
      bit done = 0;
      @(posedge clock); #1;
      if (isd) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
      else begin f_req = 1; f_addr = a; end
      start = cyc; rc = -1; ne = 0; err = 0; rd = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clock);
         if (mem_en === 1'b1) ne++;
         if ((isd ? d_ready : f_ready) === 1'b1) begin
            rc = cyc - start; err = isd ? d_err : f_err; rd = isd ? d_rdata : f_rdata; done = 1;
         end
      end
      if (!done) chk("ready_wait", 0, 1);
      @(posedge clock); #1;
      f_req = 0; d_req = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int rc, ne, nr, nf;
      logic err;
      logic [DW-1:0] rd;
      int exp3[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      int got3[10];
      f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
      mem_ack = 0; mem_rdata = 0;
      for (int i = 0; i < 256; i++) tmem[i] = 8'(i) ^ 8'h5A;
      tmem[8'h10] = 8'hA5;
      m_mem = tmem;
      repeat (3) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      chk("rst_busy", busy, 0);     chk("rst_mem_en", mem_en, 0);   chk("rst_mem_we", mem_we, 0);
      chk("rst_f_ready", f_ready, 0); chk("rst_d_ready", d_ready, 0);
      chk("rst_f_err", f_err, 0);   chk("rst_d_err", d_err, 0);
      chk("rst_f_rdata", f_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);

      // 1: single fetch, ack in first busy cycle
      ack_dly = 0;
      run_one(0, 0, 8'h10, 8'h00, rc, ne, err, rd);
      chk("t1_latency", rc, 2); chk("t1_en_cycles", ne, 1);
      chk("t1_rdata", rd, 8'hA5); chk("t1_err", err, 0);

      // 2: store, ack delayed 3 cycles
      ack_dly = 3;
      run_one(1, 1, 8'h20, 8'h3C, rc, ne, err, rd);
      chk("t2_en_cycles", ne, 4); chk("t2_latency", rc, 5); chk("t2_err", err, 0);
      chk("t2_d_rdata", rd, 8'h00); chk("t2_mem_wdata", mem_wdata, 8'h3C);

      // 3: both held continuously, grant order D,D,D,D,F,D,D,D,D,F
      ack_dly = 0; nr = 0;
      @(posedge clock); #1;
      f_req = 1; f_addr = 8'h10; d_req = 1; d_we = 0; d_addr = 8'h20;
      for (int k = 0; k < 200 && nr < 10; k++) begin
         @(negedge clock);
         if (f_ready === 1'b1) begin got3[nr] = 0; nr++; end
         else if (d_ready === 1'b1) begin got3[nr] = 1; nr++; end
      end
      @(posedge clock); #1;
      f_req = 0; d_req = 0;
      chk("t3_count", nr, 10);
      for (int i = 0; i < 10; i++) if (i < nr) chk($sformatf("t3_grant%0d", i), got3[i], exp3[i]);
      chk("t3_d_rdata", d_rdata, 8'h3C); chk("t3_f_rdata", f_rdata, 8'hA5);

      // 4: load with no ack -> timeout
      ack_dly = -1;
      run_one(1, 0, 8'h30, 8'h00, rc, ne, err, rd);
      chk("t4_en_cycles", ne, TO); chk("t4_latency", rc, TO + 1);
      chk("t4_err", err, 1); chk("t4_d_rdata", rd, 8'h3C);

      // 5: reset in the middle of a fetch
      @(posedge clock); #1;
      f_req = 1; f_addr = 8'h10;
      repeat (3) @(posedge clock);
      #1 reset = 1; f_req = 0;
      @(negedge clock);
      chk("t5_busy_before", busy, 1);
      @(posedge clock); #1 reset = 0;
      @(negedge clock);
      chk("t5_busy", busy, 0); chk("t5_mem_en", mem_en, 0); chk("t5_f_ready", f_ready, 0);
      ack_dly = 0;
      run_one(0, 0, 8'h10, 8'h00, rc, ne, err, rd);
      chk("t5_latency", rc, 2); chk("t5_rdata", rd, 8'hA5); chk("t5_err", err, 0);

      // 6: spurious mem_ack in IDLE and RESP
      spur = 1; nf = 0;
      repeat (5) begin
         @(negedge clock);
         if (f_ready === 1'b1 || d_ready === 1'b1 || busy === 1'b1) nf++;
      end
      chk("t6_idle_quiet", nf, 0);
      ack_dly = 1;
      run_one(1, 1, 8'h40, 8'h77, rc, ne, err, rd);
      chk("t6_store_latency", rc, 3); chk("t6_store_err", err, 0);
      run_one(1, 0, 8'h40, 8'h00, rc, ne, err, rd);
      chk("t6_load_rdata", rd, 8'h77); chk("t6_load_en", ne, 2);
      spur = 0;

      repeat (3) @(posedge clock);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
